// File: rtl/icache_ctrl.sv
// Direct-mapped, one-word-per-line instruction cache controller.
// Hits answer next cycle; misses fetch one word via the memory controller handshake.
module icache_ctrl #(
  parameter int INDEX_BITS    = 6,
  parameter int MEM_ADDR_BITS = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ifu_req,
  input  logic [31:0] ifu_pc,
  input  logic        ifu_flush,
  output logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_received_in,
  input  logic        mem_done_in,
  input  logic [31:0] mem_data_in,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = MEM_ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES];

  logic [31:2] pc_q, pc_d;
  logic        cancel_q, cancel_d;
  logic        inst_ready_q, inst_ready_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic                  fill_we;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic [31:0]           req_word;
  logic                  hit;
  logic                  unused_pc_lsb;

  assign req_idx  = ifu_pc[INDEX_BITS+1:2];
  assign req_tag  = ifu_pc[MEM_ADDR_BITS-1:INDEX_BITS+2];
  assign req_word = {ifu_pc[31:2], 2'b00};
  assign fill_idx = pc_q[INDEX_BITS+1:2];
  assign fill_tag = pc_q[MEM_ADDR_BITS-1:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign unused_pc_lsb = ^ifu_pc[1:0];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    cancel_d     = cancel_q;
    inst_ready_d = 1'b0;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    fill_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_req && !ifu_flush) begin
          if (hit) begin
            inst_ready_d = 1'b1;
            inst_out_d   = data_q[req_idx];
            inst_pc_d    = req_word;
            hit_cnt_d    = hit_cnt_q + 32'd1;
          end else begin
            pc_d       = ifu_pc[31:2];
            mem_req_d  = 1'b1;
            mem_addr_d = req_word;
            miss_cnt_d = miss_cnt_q + 32'd1;
            cancel_d   = 1'b0;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        // The memory request is never withdrawn; a flush only drops the answer.
        if (ifu_flush) cancel_d = 1'b1;
        if (mem_received_in) begin
          mem_req_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_done_in) begin
          fill_we          = 1'b1;
          valid_d[fill_idx] = 1'b1;
          cancel_d         = 1'b0;
          state_d          = S_IDLE;
          if (!cancel_q && !ifu_flush) begin
            inst_ready_d = 1'b1;
            inst_out_d   = mem_data_in;
            inst_pc_d    = {pc_q, 2'b00};
          end
        end else if (ifu_flush) begin
          cancel_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      pc_q         <= '0;
      cancel_q     <= 1'b0;
      inst_ready_q <= 1'b0;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      cancel_q     <= cancel_d;
      inst_ready_q <= inst_ready_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Tag/data storage carries no reset; valid_q guards it.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data_in;
    end
  end

  assign inst_ready   = inst_ready_q;
  assign inst_out     = inst_out_q;
  assign inst_pc      = inst_pc_q;
  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;
  assign hit_count    = hit_cnt_q;
  assign miss_count   = miss_cnt_q;

endmodule
